// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its line buffer.
// HALT word and address width default here unless a build-level define overrides them.
`ifndef HALT
`define HALT 16'hF000
`endif
`ifndef A_BITS
`define A_BITS 8
`endif

package fetch_pkg;
    localparam int          A_BITS    = `A_BITS;
    localparam logic [15:0] HALT_WORD = `HALT;

    typedef enum logic [1:0] {
        IDLE,
        DEMAND,
        PREF
    } fetch_state_t;

    // Tag field sized for the widest address; narrower tags are zero-extended.
    typedef struct packed {
        logic              valid;
        logic [A_BITS-1:0] tag;
        logic [15:0]       data;
    } fetch_line_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Program-memory request/acknowledge bus between the fetch unit (master) and memory (slave).
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/instr_fetch_unit_tag_array.sv
// Direct-mapped line storage: two combinational read ports, one synchronous write port,
// asynchronous clear and a synchronous flush of every valid bit (flush beats a write).
module fetch_tag_array
    import fetch_pkg::*;
#(
    parameter int LINES = 4,
    parameter int IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [IDX_W-1:0] rd_a_idx_i,
    output fetch_line_t      rd_a_line_o,
    input  logic [IDX_W-1:0] rd_b_idx_i,
    output fetch_line_t      rd_b_line_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  fetch_line_t      wr_line_i
);
    fetch_line_t lines_q [LINES];

    generate
        for (genvar gi = 0; gi < LINES; gi++) begin : g_line
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lines_q[gi] <= '0;
                end else if (flush_i) begin
                    lines_q[gi].valid <= 1'b0;
                end else if (wr_en_i && wr_idx_i == IDX_W'(gi)) begin
                    lines_q[gi] <= wr_line_i;
                end
            end
        end
    endgenerate

    assign rd_a_line_o = lines_q[rd_a_idx_i];
    assign rd_b_line_o = lines_q[rd_b_idx_i];
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: direct-mapped buffer in front of a req/ack program memory,
// presenting HALT to the core while a demand miss is serviced, with optional next-line prefetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = A_BITS,
    parameter int LINES    = 4,
    parameter int PREFETCH = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         pc_i,
    input  logic                      flush_i,
    output logic [15:0]               instruction_o,
    output logic                      miss_o,
    output logic [15:0]               miss_count_o,
    instr_fetch_unit_if.master        mem
);
    localparam int IDX_W = $clog2(LINES);

    fetch_state_t      state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pf_pend_q;
    logic [ADDR_W-1:0] pf_addr_q;
    logic              drop_q;
    logic [15:0]       miss_cnt_q;
    logic [15:0]       miss_cnt_d;

    fetch_line_t pc_line;
    fetch_line_t pf_line;
    fetch_line_t wr_line;
    logic        hit;
    logic        pf_hit;
    logic        ack;
    logic        fill_ok;

    fetch_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W)
    ) u_tags (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .rd_a_idx_i  (pc_i[IDX_W-1:0]),
        .rd_a_line_o (pc_line),
        .rd_b_idx_i  (pf_addr_q[IDX_W-1:0]),
        .rd_b_line_o (pf_line),
        .wr_en_i     (fill_ok),
        .wr_idx_i    (addr_q[IDX_W-1:0]),
        .wr_line_i   (wr_line)
    );

    assign hit     = pc_line.valid && (pc_line.tag == A_BITS'(pc_i >> IDX_W));
    assign pf_hit  = pf_line.valid && (pf_line.tag == A_BITS'(pf_addr_q >> IDX_W));
    assign ack     = req_q && mem.mem_ack;
    // A flush in the ack cycle, or any flush while the request was outstanding, discards the fill.
    assign fill_ok = ack && !flush_i && !drop_q;

    assign wr_line = '{valid: 1'b1, tag: A_BITS'(addr_q >> IDX_W), data: mem.mem_rdata};

    assign instruction_o = hit ? pc_line.data : HALT_WORD;
    assign miss_o        = !hit;
    assign miss_count_o  = miss_cnt_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_addr  = addr_q;

    assign miss_cnt_d = (miss_o && miss_cnt_q != 16'hFFFF) ? miss_cnt_q + 16'd1 : miss_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            pf_pend_q  <= 1'b0;
            pf_addr_q  <= '0;
            drop_q     <= 1'b0;
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            case (state_q)
                IDLE: begin
                    if (miss_o) begin
                        state_q   <= DEMAND;
                        req_q     <= 1'b1;
                        addr_q    <= pc_i;
                        drop_q    <= 1'b0;
                        pf_pend_q <= 1'b0;
                    end else if (pf_pend_q && !pf_hit && !flush_i) begin
                        state_q <= PREF;
                        req_q   <= 1'b1;
                        addr_q  <= pf_addr_q;
                        drop_q  <= 1'b0;
                    end
                end
                DEMAND: begin
                    if (ack) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        pf_pend_q <= fill_ok && (PREFETCH != 0);
                        pf_addr_q <= addr_q + ADDR_W'(1);
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                PREF: begin
                    if (ack) begin
                        state_q   <= IDLE;
                        req_q     <= 1'b0;
                        pf_pend_q <= 1'b0;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
            if (flush_i) begin
                pf_pend_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit: a cycle-level reference model predicts
// core-side outputs and memory requests; a negedge monitor compares them with the DUT.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    localparam int AW   = 8;
    localparam int LN   = 4;
    localparam int NMEM = 256;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [AW-1:0] pc = '0;
    logic          flush = 1'b0;
    logic [15:0]   instr;
    logic          miss;
    logic [15:0]   mcount;

    instr_fetch_unit_if #(.ADDR_W(AW)) mif ();

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .LINES    (LN),
        .PREFETCH (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc),
        .flush_i       (flush),
        .instruction_o (instr),
        .miss_o        (miss),
        .miss_count_o  (mcount),
        .mem           (mif.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]   instr;
        logic          miss;
        logic          req;
        logic [AW-1:0] addr;
        logic [15:0]   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [15:0] mem_img [NMEM];

    // Reference model: buffer contents by full address, plus the one outstanding memory transaction.
    bit          m_valid [LN];
    int          m_addr  [LN];
    logic [15:0] m_data  [LN];
    bit          m_busy, m_demand, m_drop, m_pf_pend;
    int          m_req_addr, m_pf_addr, m_wait, m_cnt;
    int          force_lat = 0;
    int          cur_pc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < LN; i++) m_valid[i] = 1'b0;
        m_busy = 0; m_drop = 0; m_pf_pend = 0; m_demand = 0;
        m_req_addr = 0; m_pf_addr = 0; m_wait = 0; m_cnt = 0;
    endtask

    function automatic bit model_hit(input int a);
        return m_valid[a % LN] && m_addr[a % LN] == a;
    endfunction

    task automatic start_req(input int a, input bit demand);
        int lat;
        lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
        m_busy = 1; m_demand = demand; m_req_addr = a; m_drop = 0; m_wait = lat - 1;
        $display("req %s addr=%0d latency=%0d", demand ? "demand" : "prefetch", a, lat);
    endtask

    // One core cycle: predict outputs, drive inputs, then advance the model past the next edge.
    task automatic step(input int p, input bit f, output bit h);
        exp_t e;
        bit   ack;
        h   = model_hit(p);
        ack = m_busy && m_wait == 0;
        e.instr = h ? m_data[p % LN] : HALT_WORD;
        e.miss  = !h;
        e.req   = m_busy;
        e.addr  = AW'(m_req_addr);
        e.cnt   = 16'(m_cnt);
        sb.push_back(e);

        pc    = AW'(p);
        flush = f;
        if (ack) begin
            mif.mem_ack   = 1'b1;
            mif.mem_rdata = mem_img[m_req_addr];
        end else begin
            mif.mem_ack   = (!m_busy && $urandom_range(0, 4) == 0);
            mif.mem_rdata = 16'($urandom());
        end

        if (!h && m_cnt < 65535) m_cnt++;
        if (ack) begin
            if (!f && !m_drop) begin
                m_valid[m_req_addr % LN] = 1;
                m_addr[m_req_addr % LN]  = m_req_addr;
                m_data[m_req_addr % LN]  = mem_img[m_req_addr];
            end
            m_pf_pend = m_demand && !f && !m_drop;
            if (m_demand) m_pf_addr = (m_req_addr + 1) % NMEM;
            m_busy = 0;
        end else if (m_busy) begin
            m_wait--;
            if (f) m_drop = 1;
        end else if (!h) begin
            start_req(p, 1);
            m_pf_pend = 0;
        end else if (m_pf_pend && !f && !model_hit(m_pf_addr)) begin
            start_req(m_pf_addr, 0);
            m_pf_pend = 0;
        end
        if (f) begin
            for (int i = 0; i < LN; i++) m_valid[i] = 0;
            m_pf_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int p, input int maxc);
        bit h;
        h = 0;
        for (int i = 0; i < maxc && !h; i++) step(p, 1'b0, h);
        n_vec++;
        if (!h) begin
            n_err++;
            $display("FAIL settle: pc=%0d still missing after %0d cycles", p, maxc);
        end
    endtask

    task automatic run_core(input int n, input int jump_pct, input int flush_pct);
        bit h;
        bit f;
        int p;
        p = cur_pc;
        for (int i = 0; i < n; i++) begin
            f = ($urandom_range(0, 99) < flush_pct);
            step(p, f, h);
            if ($urandom_range(0, 99) < jump_pct)
                p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(248, 255)) : int'($urandom_range(0, 19));
            else if (h)
                p = (p + 1) % NMEM;
        end
        cur_pc = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc = '0; flush = 1'b0; mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        #2;
        chk("reset_instruction", 32'(instr), 32'(HALT_WORD));
        chk("reset_miss", 32'(miss), 32'd1);
        chk("reset_mem_req", 32'(mif.mem_req), 32'd0);
        chk("reset_mem_addr", 32'(mif.mem_addr), 32'd0);
        chk("reset_miss_count", 32'(mcount), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cur_pc = 0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            chk("instruction", 32'(instr), 32'(e.instr));
            chk("miss", 32'(miss), 32'(e.miss));
            chk("mem_req", 32'(mif.mem_req), 32'(e.req));
            if (e.req) chk("mem_addr", 32'(mif.mem_addr), 32'(e.addr));
            chk("miss_count", 32'(mcount), 32'(e.cnt));
        end
    end

    initial begin
        bit h;
        for (int i = 0; i < NMEM; i++) mem_img[i] = 16'($urandom());
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        #1;
        do_reset();

        // Cold start at pc=0 with single-cycle memory, then a straight-line run.
        force_lat = 1;
        run_core(24, 0, 0);

        // Jump while a demand is outstanding: both lines end up filled.
        force_lat = 3;
        step(8, 1'b0, h);
        settle(3, 20);
        settle(8, 20);

        // Same-index conflict between 2 and 6.
        force_lat = 0;
        settle(2, 20);
        settle(6, 20);
        settle(2, 20);

        // Flush coinciding with the demand ack for pc=5.
        force_lat = 2;
        step(13, 1'b1, h);
        step(5, 1'b0, h);
        step(5, 1'b0, h);
        step(5, 1'b1, h);
        settle(5, 20);

        // Address wrap with slow memory: prefetch of 0 after filling 255.
        force_lat = 4;
        settle(255, 20);
        for (int i = 0; i < 8; i++) step(255, 1'b0, h);
        settle(0, 20);

        force_lat = 0;
        cur_pc = 0;
        run_core(2000, 10, 3);

        do_reset();
        run_core(1500, 8, 2);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
